// File: rtl/pkt_drop_wait_pkg.sv
// ============================================================================
// Module   : pkt_drop_wait_pkg
// Shared types, default widths and saturating-increment helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

// Packet width normally comes from spio_hss_multiplexer_common.h.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

package pkt_drop_wait_pkg;

    localparam int unsigned PKT_W              = `PKT_BITS;
    localparam int unsigned DEF_DROP_WAIT_BITS = 16;
    localparam int unsigned DEF_DROP_CNT_BITS  = 32;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } head_st_e;

    function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max);
        return (val >= max) ? max : val + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_skid_buf.sv
// ============================================================================
// Module   : pkt_skid_buf
// Two-entry skid buffer (head + skid) with registered ready and external pop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_skid_buf
    import pkt_drop_wait_pkg::*;
#(
    parameter int unsigned WIDTH = PKT_W
) (
    input  logic             clk_tb,
    input  logic             reset_tb,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_vld_i,
    output logic             push_rdy_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_vld_o,
    input  logic             pop_i
);

    head_st_e         head_st_q, head_st_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_vld_q, skid_vld_d;
    logic             rdy_q;
    logic             w_push;

    // Ready high means the skid is empty, so an accepted word always has a home.
    assign w_push = push_vld_i & rdy_q;

    always_comb begin
        head_st_d  = head_st_q;
        head_d     = head_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if ((head_st_q == EMPTY) || pop_i) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_st_d  = FULL;
                skid_vld_d = 1'b0;
            end else if (w_push) begin
                head_d    = push_data_i;
                head_st_d = FULL;
            end else begin
                head_st_d = EMPTY;
            end
        end else if (w_push) begin
            skid_d     = push_data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            head_st_q  <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            head_st_q  <= head_st_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= ~skid_vld_d;
        end
    end

    assign push_rdy_o  = rdy_q;
    assign head_data_o = head_q;
    assign head_vld_o  = (head_st_q == FULL);

endmodule

`default_nettype wire

// File: rtl/pkt_drop_wait.sv
// ============================================================================
// Module   : pkt_drop_wait
// Output stage forwarding packets; drops a head refused longer than a wait limit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_drop_wait
    import pkt_drop_wait_pkg::*;
#(
    parameter int unsigned DROP_WAIT_BITS = DEF_DROP_WAIT_BITS,
    parameter int unsigned DROP_CNT_BITS  = DEF_DROP_CNT_BITS
) (
    input  logic                      clk_tb,
    input  logic                      reset_tb,
    input  logic [DROP_WAIT_BITS-1:0] drop_wait_in,
    input  logic                      drop_cnt_clr_in,
    input  logic [`PKT_BITS-1:0]      pkt_data_in,
    input  logic                      pkt_vld_in,
    output logic                      pkt_rdy_out,
    output logic [`PKT_BITS-1:0]      pkt_data_out,
    output logic                      pkt_vld_out,
    input  logic                      pkt_rdy_in,
    output logic [DROP_CNT_BITS-1:0]  drop_cnt_out,
    output logic                      drop_evt_out
);

    localparam logic [DROP_WAIT_BITS-1:0] WAIT_MAX = {DROP_WAIT_BITS{1'b1}};
    localparam logic [DROP_CNT_BITS-1:0]  CNT_MAX  = {DROP_CNT_BITS{1'b1}};

    logic [DROP_WAIT_BITS-1:0] wait_q, wait_d;
    logic [DROP_CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                      evt_q;
    logic                      w_xfer, w_drop, w_wait_hit;

    pkt_skid_buf #(
        .WIDTH (`PKT_BITS)
    ) u_skid (
        .clk_tb      (clk_tb),
        .reset_tb    (reset_tb),
        .push_data_i (pkt_data_in),
        .push_vld_i  (pkt_vld_in),
        .push_rdy_o  (pkt_rdy_out),
        .head_data_o (pkt_data_out),
        .head_vld_o  (pkt_vld_out),
        .pop_i       (w_xfer | w_drop)
    );

    // A saturated counter also times out, so lowering the limit mid-wait cannot strand the head.
    assign w_wait_hit = (drop_wait_in != '0) &&
                        ((wait_q == drop_wait_in - DROP_WAIT_BITS'(1)) || (wait_q == WAIT_MAX));
    assign w_xfer     = pkt_vld_out & pkt_rdy_in;
    assign w_drop     = pkt_vld_out & ~pkt_rdy_in & w_wait_hit;

    always_comb begin
        wait_d = wait_q;
        if (!pkt_vld_out || w_xfer || w_drop) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + DROP_WAIT_BITS'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (drop_cnt_clr_in) begin
            cnt_d = w_drop ? DROP_CNT_BITS'(1) : '0;
        end else if (w_drop) begin
            cnt_d = DROP_CNT_BITS'(sat_inc(64'(cnt_q), 64'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            wait_q <= '0;
            cnt_q  <= '0;
            evt_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            cnt_q  <= cnt_d;
            evt_q  <= w_drop;
        end
    end

    assign drop_cnt_out = cnt_q;
    assign drop_evt_out = evt_q;

endmodule

`default_nettype wire
